// File: rtl/dma_pkg.sv
// Shared definitions for the DMA reader/writer pair.
// Contents:
//   REG_*        byte offsets of the configuration registers in the dbus window
//   STAT_*       bit positions inside the STATUS register
//   dma_state_e  transfer FSM encoding used by both DMA directions
//   reg_offset   turns dbus word-select bits into a byte offset for decoding
package dma_pkg;

  localparam logic [4:0] REG_ADDR   = 5'h00;
  localparam logic [4:0] REG_STEP   = 5'h04;
  localparam logic [4:0] REG_CYCLES = 5'h08;
  localparam logic [4:0] REG_BLOCKS = 5'h0C;
  localparam logic [4:0] REG_START  = 5'h10;
  localparam logic [4:0] REG_STOP   = 5'h14;
  localparam logic [4:0] REG_STATUS = 5'h18;
  localparam logic [4:0] REG_RSVD   = 5'h1C;

  localparam int STAT_BLOCK_DONE = 0;
  localparam int STAT_XFER_DONE  = 1;
  localparam int STAT_FINISHED   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REQ  = 2'd2,
    ST_PUSH = 2'd3
  } dma_state_e;

  // Register decode works on whole words; the two byte-lane bits are ignored.
  function automatic logic [4:0] reg_offset(input logic [2:0] word_sel);
    return {word_sel, 2'b00};
  endfunction

endpackage

// File: rtl/dma_regs.sv
// Configuration register block for the DMA engines (dbus wishbone slave).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_dbus_cyc/we/adr/dat   slave request from the CPU
//   dbus_rdt, dbus_ack       read data (zero outside the ack cycle), ack pulse
//   status                   {finished, xfer_done, block_done} from the engine
//   cfg_addr/step/cycles/blocks  current configuration
//   start_pulse, start_repeat    START written (held repeat bit alongside)
//   stop_pulse                   STOP written
//   wr_busy                  a register write is being accepted or just landed;
//                            the engine holds off new block requests meanwhile
module dma_regs
  import dma_pkg::*;
#(
  parameter logic [31:0] ADDR  = 32'h65,
  parameter int          WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_dbus_cyc,
  input  logic        wb_dbus_we,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  output logic [31:0] dbus_rdt,
  output logic        dbus_ack,
  input  logic [2:0]  status,
  output logic [31:0] cfg_addr,
  output logic [31:0] cfg_step,
  output logic [31:0] cfg_cycles,
  output logic [31:0] cfg_blocks,
  output logic        start_pulse,
  output logic        start_repeat,
  output logic        stop_pulse,
  output logic        wr_busy
);

  logic        ack_q, ack_d;
  logic [31:0] rdt_q, rdt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] step_q, step_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] blocks_q, blocks_d;
  logic        start_q, start_d;
  logic        repeat_q, repeat_d;
  logic        stop_q, stop_d;
  logic        wr_ack_q, wr_ack_d;

  logic        sel_match;
  logic        hit;
  logic [4:0]  offset;
  logic        unused_adr_bits;

  assign sel_match = (wb_dbus_adr[31 -: WIDTH] == ADDR[WIDTH-1:0]);
  // The ~ack_q term makes every access exactly one ack long even though the
  // master only drops cyc in the ack cycle.
  assign hit       = wb_dbus_cyc & sel_match & ~ack_q;
  assign offset    = reg_offset(wb_dbus_adr[4:2]);
  assign unused_adr_bits = ^{wb_dbus_adr[31-WIDTH:5], wb_dbus_adr[1:0]};

  always_comb begin
    ack_d    = hit;
    rdt_d    = '0;
    addr_d   = addr_q;
    step_d   = step_q;
    cycles_d = cycles_q;
    blocks_d = blocks_q;
    start_d  = 1'b0;
    repeat_d = repeat_q;
    stop_d   = 1'b0;
    wr_ack_d = hit & wb_dbus_we;
    if (hit && wb_dbus_we) begin
      case (offset)
        REG_ADDR:   addr_d   = wb_dbus_dat;
        REG_STEP:   step_d   = wb_dbus_dat;
        REG_CYCLES: cycles_d = wb_dbus_dat;
        REG_BLOCKS: blocks_d = wb_dbus_dat;
        REG_START: begin
          start_d  = 1'b1;
          repeat_d = wb_dbus_dat[0];
        end
        REG_STOP:   stop_d   = 1'b1;
        default: ;
      endcase
    end else if (hit) begin
      case (offset)
        REG_ADDR:   rdt_d = addr_q;
        REG_STEP:   rdt_d = step_q;
        REG_CYCLES: rdt_d = cycles_q;
        REG_BLOCKS: rdt_d = blocks_q;
        REG_STATUS: rdt_d = {29'd0, status};
        default:    rdt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      rdt_q    <= '0;
      addr_q   <= '0;
      step_q   <= '0;
      cycles_q <= '0;
      blocks_q <= '0;
      start_q  <= 1'b0;
      repeat_q <= 1'b0;
      stop_q   <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      rdt_q    <= rdt_d;
      addr_q   <= addr_d;
      step_q   <= step_d;
      cycles_q <= cycles_d;
      blocks_q <= blocks_d;
      start_q  <= start_d;
      repeat_q <= repeat_d;
      stop_q   <= stop_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign dbus_ack     = ack_q;
  assign dbus_rdt     = rdt_q;
  assign cfg_addr     = addr_q;
  assign cfg_step     = step_q;
  assign cfg_cycles   = cycles_q;
  assign cfg_blocks   = blocks_q;
  assign start_pulse  = start_q;
  assign start_repeat = repeat_q;
  assign stop_pulse   = stop_q;
  assign wr_busy      = (hit & wb_dbus_we) | wr_ack_q;

endmodule

// File: rtl/dma_reader.sv
// Memory-to-peripheral DMA engine (read direction).
// Ports:
//   wb_clk, wb_rst           clock, synchronous active-high reset
//   wb_dbus_*, dbus_rdt/ack  CPU configuration port (see dma_regs)
//   xfer_block               request one more block from memory
//   xfer_we/adr/dat          sink write port, one strobe per fetched word
//   block_done, xfer_done    progress flags (also visible in STATUS)
//   dma_cyc/we/sel/adr/dat   read-only wishbone master towards RAM
//   dma_ack, dma_rdt         master ack and read data
module dma_reader
  import dma_pkg::*;
#(
  parameter logic [31:0] ADDR        = 32'h65,
  parameter int          WIDTH       = 8,
  parameter int          XFER_ADDR_W = 16
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic                   wb_dbus_cyc,
  input  logic                   wb_dbus_we,
  input  logic [31:0]            wb_dbus_adr,
  input  logic [31:0]            wb_dbus_dat,
  output logic [31:0]            dbus_rdt,
  output logic                   dbus_ack,
  input  logic                   xfer_block,
  output logic                   xfer_we,
  output logic [XFER_ADDR_W-1:0] xfer_adr,
  output logic [31:0]            xfer_dat,
  output logic                   block_done,
  output logic                   xfer_done,
  output logic                   dma_cyc,
  output logic                   dma_we,
  output logic [3:0]             dma_sel,
  output logic [31:0]            dma_adr,
  output logic [31:0]            dma_dat,
  input  logic                   dma_ack,
  input  logic [31:0]            dma_rdt
);

  logic [31:0] cfg_addr, cfg_step, cfg_cycles, cfg_blocks;
  logic        start_pulse, start_repeat, stop_pulse, wr_busy;
  logic [2:0]  status;

  dma_state_e  state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] blk_q, blk_d;
  logic        block_done_q, block_done_d;
  logic        xfer_done_q, xfer_done_d;
  logic        finished_q, finished_d;
  logic        repeat_q, repeat_d;
  logic        done_pulse_q, done_pulse_d;
  logic        pend_q, pend_d;
  logic        stopping_q, stopping_d;
  logic        dma_cyc_q, dma_cyc_d;
  logic [31:0] dma_adr_q, dma_adr_d;
  logic        xfer_we_q, xfer_we_d;
  logic [XFER_ADDR_W-1:0] xfer_adr_q, xfer_adr_d;
  logic [31:0] xfer_dat_q, xfer_dat_d;

  logic        cfg_ok, last_word, last_blk, block_req;

  always_comb begin
    status                  = '0;
    status[STAT_BLOCK_DONE] = block_done_q;
    status[STAT_XFER_DONE]  = xfer_done_q;
    status[STAT_FINISHED]   = finished_q;
  end

  dma_regs #(
    .ADDR  (ADDR),
    .WIDTH (WIDTH)
  ) u_regs (
    .clk          (wb_clk),
    .rst          (wb_rst),
    .wb_dbus_cyc  (wb_dbus_cyc),
    .wb_dbus_we   (wb_dbus_we),
    .wb_dbus_adr  (wb_dbus_adr),
    .wb_dbus_dat  (wb_dbus_dat),
    .dbus_rdt     (dbus_rdt),
    .dbus_ack     (dbus_ack),
    .status       (status),
    .cfg_addr     (cfg_addr),
    .cfg_step     (cfg_step),
    .cfg_cycles   (cfg_cycles),
    .cfg_blocks   (cfg_blocks),
    .start_pulse  (start_pulse),
    .start_repeat (start_repeat),
    .stop_pulse   (stop_pulse),
    .wr_busy      (wr_busy)
  );

  assign cfg_ok    = (cfg_cycles != 32'd0) && (cfg_blocks != 32'd0);
  assign last_word = !((idx_q + 32'd1) < cfg_cycles);
  assign last_blk  = !((blk_q + 32'd1) < cfg_blocks);
  // A block request that collides with a register write is parked in pend_q
  // and replayed once the write has landed.
  assign block_req = xfer_block | pend_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    blk_d        = blk_q;
    block_done_d = block_done_q;
    xfer_done_d  = xfer_done_q;
    finished_d   = finished_q;
    repeat_d     = repeat_q;
    done_pulse_d = done_pulse_q;
    pend_d       = pend_q;
    stopping_d   = stopping_q;
    dma_cyc_d    = dma_cyc_q;
    dma_adr_d    = dma_adr_q;
    xfer_we_d    = 1'b0;
    xfer_adr_d   = xfer_adr_q;
    xfer_dat_d   = '0;

    // A START seen mid-pass only retargets the repeat decision.
    if (start_pulse) repeat_d = start_repeat;

    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          ptr_d        = cfg_addr;
          idx_d        = '0;
          blk_d        = '0;
          block_done_d = 1'b0;
          xfer_done_d  = 1'b0;
          finished_d   = 1'b0;
          done_pulse_d = 1'b0;
          pend_d       = 1'b0;
          if (cfg_ok) begin
            state_d = ST_WAIT;
          end else begin
            // Empty transfer: finished at once, never touches the bus.
            xfer_done_d = 1'b1;
            finished_d  = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (done_pulse_q) begin
          xfer_done_d  = 1'b0;
          done_pulse_d = 1'b0;
        end
        if (block_req && !xfer_done_q) begin
          if (wr_busy) begin
            pend_d = 1'b1;
          end else begin
            pend_d       = 1'b0;
            block_done_d = 1'b0;
            dma_cyc_d    = 1'b1;
            dma_adr_d    = ptr_q;
            state_d      = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (dma_ack) begin
          dma_cyc_d = 1'b0;
          ptr_d     = ptr_q + cfg_step;
          if (stopping_q) begin
            // Bus cycle finished for a stopped transfer; drop the word.
            stopping_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            xfer_we_d  = 1'b1;
            xfer_dat_d = dma_rdt;
            xfer_adr_d = idx_q[XFER_ADDR_W-1:0];
            state_d    = ST_PUSH;
          end
        end
      end

      ST_PUSH: begin
        if (!last_word) begin
          idx_d     = idx_q + 32'd1;
          dma_cyc_d = 1'b1;
          dma_adr_d = ptr_q;
          state_d   = ST_REQ;
        end else begin
          idx_d        = '0;
          blk_d        = blk_q + 32'd1;
          block_done_d = 1'b1;
          if (!last_blk) begin
            state_d = ST_WAIT;
          end else if (!repeat_q) begin
            xfer_done_d = 1'b1;
            finished_d  = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            // Looping pass: announce completion for one cycle and rewind.
            xfer_done_d  = 1'b1;
            done_pulse_d = 1'b1;
            ptr_d        = cfg_addr;
            blk_d        = '0;
            state_d      = ST_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // STOP wins over the normal flow, except that an open bus cycle must be
    // allowed to finish before the engine can go idle.
    if (stop_pulse) begin
      block_done_d = 1'b0;
      xfer_done_d  = 1'b0;
      finished_d   = 1'b0;
      done_pulse_d = 1'b0;
      pend_d       = 1'b0;
      if (state_q == ST_REQ && !dma_ack) begin
        stopping_d = 1'b1;
      end else begin
        state_d    = ST_IDLE;
        dma_cyc_d  = 1'b0;
        xfer_we_d  = 1'b0;
        xfer_dat_d = '0;
        stopping_d = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      blk_q        <= '0;
      block_done_q <= 1'b0;
      xfer_done_q  <= 1'b0;
      finished_q   <= 1'b0;
      repeat_q     <= 1'b0;
      done_pulse_q <= 1'b0;
      pend_q       <= 1'b0;
      stopping_q   <= 1'b0;
      dma_cyc_q    <= 1'b0;
      dma_adr_q    <= '0;
      xfer_we_q    <= 1'b0;
      xfer_adr_q   <= '0;
      xfer_dat_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      blk_q        <= blk_d;
      block_done_q <= block_done_d;
      xfer_done_q  <= xfer_done_d;
      finished_q   <= finished_d;
      repeat_q     <= repeat_d;
      done_pulse_q <= done_pulse_d;
      pend_q       <= pend_d;
      stopping_q   <= stopping_d;
      dma_cyc_q    <= dma_cyc_d;
      dma_adr_q    <= dma_adr_d;
      xfer_we_q    <= xfer_we_d;
      xfer_adr_q   <= xfer_adr_d;
      xfer_dat_q   <= xfer_dat_d;
    end
  end

  assign xfer_we    = xfer_we_q;
  assign xfer_adr   = xfer_adr_q;
  assign xfer_dat   = xfer_dat_q;
  assign block_done = block_done_q;
  assign xfer_done  = xfer_done_q;
  assign dma_cyc    = dma_cyc_q;
  assign dma_we     = 1'b0;
  assign dma_sel    = dma_cyc_q ? 4'hF : 4'h0;
  assign dma_adr    = dma_adr_q;
  assign dma_dat    = '0;

endmodule

// File: tb/tb_dma_reader.sv
// Self-checking bench for dma_reader: a RAM model answers the DMA master,
// expected sink words are queued when the RAM answers and compared when the
// DUT presents them on the xfer port.
module tb_dma_reader;
  import dma_pkg::*;

  localparam logic [31:0] BASE = 32'h6500_0000;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        wb_dbus_cyc, wb_dbus_we;
  logic [31:0] wb_dbus_adr, wb_dbus_dat;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic        xfer_block;
  logic        xfer_we;
  logic [15:0] xfer_adr;
  logic [31:0] xfer_dat;
  logic        block_done, xfer_done;
  logic        dma_cyc, dma_we;
  logic [3:0]  dma_sel;
  logic [31:0] dma_adr, dma_dat;
  logic        dma_ack;
  logic [31:0] dma_rdt;

  dma_reader dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .wb_dbus_cyc (wb_dbus_cyc),
    .wb_dbus_we  (wb_dbus_we),
    .wb_dbus_adr (wb_dbus_adr),
    .wb_dbus_dat (wb_dbus_dat),
    .dbus_rdt    (dbus_rdt),
    .dbus_ack    (dbus_ack),
    .xfer_block  (xfer_block),
    .xfer_we     (xfer_we),
    .xfer_adr    (xfer_adr),
    .xfer_dat    (xfer_dat),
    .block_done  (block_done),
    .xfer_done   (xfer_done),
    .dma_cyc     (dma_cyc),
    .dma_we      (dma_we),
    .dma_sel     (dma_sel),
    .dma_adr     (dma_adr),
    .dma_dat     (dma_dat),
    .dma_ack     (dma_ack),
    .dma_rdt     (dma_rdt)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  off;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] idx;
    logic [31:0] dat;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] addr_q[$];
  vec_t        vecs[$];

  int check_cnt = 0;
  int pass_cnt = 0;
  int viol = 0;
  int words_seen = 0;
  int cyc_seen = 0;
  int wait_cnt = 0;
  int ack_delay = 0;
  int model_idx = 0;
  int model_cycles = 1;
  bit discard = 1'b0;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic protoViolation(input string name, input logic [31:0] act);
    viol++;
    $display("[TB] FAIL %s: got 0x%08h at %0t", name, act, $time);
  endtask

  // One clock: sample DUT at the falling edge, then play RAM slave.
  task automatic tick();
    sb_t e;
    @(negedge wb_clk);
    if (!dbus_ack && dbus_rdt !== 32'd0) protoViolation("dbus_rdt while idle", dbus_rdt);
    if (!xfer_we && xfer_dat !== 32'd0) protoViolation("xfer_dat while idle", xfer_dat);
    if (dma_sel !== (dma_cyc ? 4'hF : 4'h0)) protoViolation("dma_sel", {28'd0, dma_sel});
    if (dma_we !== 1'b0 || dma_dat !== 32'd0) protoViolation("dma_we/dma_dat", dma_dat);
    if (dma_cyc) cyc_seen++;
    if (xfer_we) begin
      words_seen++;
      if (sb_q.size() == 0) begin
        checkOutput("scoreboard depth at xfer_we", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        checkOutput("xfer_adr", {16'd0, xfer_adr}, {16'd0, e.idx});
        checkOutput("xfer_dat", xfer_dat, e.dat);
      end
    end
    if (dma_ack) begin
      dma_ack  = 1'b0;
      dma_rdt  = '0;
      wait_cnt = 0;
    end else if (dma_cyc) begin
      if (wait_cnt >= ack_delay) begin
        dma_ack = 1'b1;
        dma_rdt = ram_word(dma_adr);
        if (addr_q.size() == 0)
          checkOutput("addr queue depth at dma fetch", 32'(addr_q.size()), 32'd1);
        else
          checkOutput("dma_adr", dma_adr, addr_q.pop_front());
        if (!discard) begin
          e.idx = 16'(model_idx);
          e.dat = ram_word(dma_adr);
          sb_q.push_back(e);
          model_idx = (model_idx + 1) % model_cycles;
        end
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic dbusAccess(input logic we, input logic [4:0] off, input logic [31:0] wdat,
                            output logic [31:0] rdt);
    logic ok;
    ok = 1'b0;
    rdt = '0;
    wb_dbus_cyc = 1'b1;
    wb_dbus_we  = we;
    wb_dbus_adr = BASE | {27'd0, off};
    wb_dbus_dat = wdat;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (dbus_ack) begin
        rdt = dbus_rdt;
        ok  = 1'b1;
      end
    end
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
    wb_dbus_adr = '0;
    wb_dbus_dat = '0;
    if (!ok) checkOutput("dbus ack timeout", {31'd0, ok}, 32'd1);
    tick();
  endtask

  task automatic applyStimulus(input vec_t v, output logic [31:0] rdt);
    if (v.rst) begin
      wb_rst = 1'b1;
      tick();
      wb_rst = 1'b0;
      tick();
    end
    dbusAccess(v.we, v.off, v.wdat, rdt);
  endtask

  task automatic regWrite(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    dbusAccess(1'b1, off, d, dummy);
  endtask

  task automatic regRead(input logic [4:0] off, output logic [31:0] d);
    dbusAccess(1'b0, off, 32'd0, d);
  endtask

  task automatic pulseBlock();
    xfer_block = 1'b1;
    tick();
    xfer_block = 1'b0;
  endtask

  task automatic waitWords(input int target, input string name);
    for (int i = 0; i < 200 && words_seen < target; i++) tick();
    checkOutput(name, 32'(words_seen), 32'(target));
  endtask

  task automatic setup(input logic [31:0] a, input logic [31:0] s, input logic [31:0] c,
                       input logic [31:0] b, input logic [31:0] start);
    regWrite(REG_ADDR, a);
    regWrite(REG_STEP, s);
    regWrite(REG_CYCLES, c);
    regWrite(REG_BLOCKS, b);
    regWrite(REG_START, start);
  endtask

  initial begin
    logic [31:0] rd;
    int base_words, base_cyc;

    wb_rst = 1'b1;
    wb_dbus_cyc = 1'b0; wb_dbus_we = 1'b0; wb_dbus_adr = '0; wb_dbus_dat = '0;
    xfer_block = 1'b0; dma_ack = 1'b0; dma_rdt = '0;
    repeat (3) tick();
    wb_rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset dma_cyc", {31'd0, dma_cyc}, 32'd0);
    checkOutput("reset xfer_we", {31'd0, xfer_we}, 32'd0);
    checkOutput("reset flags", {30'd0, xfer_done, block_done}, 32'd0);
    checkOutput("reset xfer_adr", {16'd0, xfer_adr}, 32'd0);
    checkOutput("reset dbus_ack", {31'd0, dbus_ack}, 32'd0);
    tick();

    $display("[TB] case 1: two blocks of four words");
    model_cycles = 4;
    for (int k = 0; k < 8; k++) addr_q.push_back(32'h0001_0000 + 32'(4 * k));
    setup(32'h0001_0000, 32'd4, 32'd4, 32'd2, 32'd0);
    pulseBlock();
    waitWords(4, "block 1 words");
    tick(); tick();
    checkOutput("block 1 flags", {30'd0, xfer_done, block_done}, 32'd1);
    pulseBlock();
    waitWords(8, "block 2 words");
    tick(); tick();
    checkOutput("pass end flags", {30'd0, xfer_done, block_done}, 32'd3);
    regRead(REG_STATUS, rd);
    checkOutput("case 1 STATUS", rd, 32'd7);

    $display("[TB] case 2: block request after completion");
    base_words = words_seen; base_cyc = cyc_seen;
    pulseBlock();
    repeat (8) tick();
    checkOutput("no fetch after done", 32'(cyc_seen - base_cyc), 32'd0);
    checkOutput("no word after done", 32'(words_seen - base_words), 32'd0);
    checkOutput("flags held", {30'd0, xfer_done, block_done}, 32'd3);

    $display("[TB] case 3: register table");
    vecs.push_back('{1'b0, 1'b1, REG_ADDR,   32'h0002_0000, 32'd0});
    vecs.push_back('{1'b0, 1'b1, REG_STEP,   32'd8,         32'd0});
    vecs.push_back('{1'b0, 1'b1, REG_CYCLES, 32'd3,         32'd0});
    vecs.push_back('{1'b0, 1'b1, REG_BLOCKS, 32'd5,         32'd0});
    vecs.push_back('{1'b0, 1'b0, REG_ADDR,   32'd0,         32'h0002_0000});
    vecs.push_back('{1'b0, 1'b0, REG_STEP,   32'd0,         32'd8});
    vecs.push_back('{1'b0, 1'b0, REG_CYCLES, 32'd0,         32'd3});
    vecs.push_back('{1'b0, 1'b0, REG_BLOCKS, 32'd0,         32'd5});
    vecs.push_back('{1'b0, 1'b0, REG_STATUS, 32'd0,         32'd7});
    vecs.push_back('{1'b0, 1'b0, REG_START,  32'd0,         32'd0});
    vecs.push_back('{1'b0, 1'b0, REG_STOP,   32'd0,         32'd0});
    vecs.push_back('{1'b0, 1'b0, REG_RSVD,   32'd0,         32'd0});
    vecs.push_back('{1'b0, 1'b1, REG_STATUS, 32'd0,         32'd0});
    vecs.push_back('{1'b0, 1'b0, REG_STATUS, 32'd0,         32'd7});
    vecs.push_back('{1'b1, 1'b0, REG_ADDR,   32'd0,         32'd0});
    vecs.push_back('{1'b0, 1'b0, REG_STEP,   32'd0,         32'd0});
    vecs.push_back('{1'b0, 1'b0, REG_CYCLES, 32'd0,         32'd0});
    vecs.push_back('{1'b0, 1'b0, REG_BLOCKS, 32'd0,         32'd0});
    vecs.push_back('{1'b0, 1'b0, REG_STATUS, 32'd0,         32'd0});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], rd);
      if (!vecs[i].we) checkOutput($sformatf("reg vec %0d", i), rd, vecs[i].exp);
    end

    $display("[TB] case 4: repeat mode");
    model_cycles = 2;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 4; k++) addr_q.push_back(32'h0001_0000 + 32'(4 * k));
    base_words = words_seen;
    setup(32'h0001_0000, 32'd4, 32'd2, 32'd2, 32'd1);
    pulseBlock();
    waitWords(base_words + 2, "repeat block 1 words");
    tick(); tick();
    pulseBlock();
    waitWords(base_words + 4, "repeat block 2 words");
    tick();
    checkOutput("repeat xfer_done pulse", {31'd0, xfer_done}, 32'd1);
    tick();
    checkOutput("repeat xfer_done clears", {31'd0, xfer_done}, 32'd0);
    regWrite(REG_START, 32'd0);
    pulseBlock();
    waitWords(base_words + 6, "second pass block 1 words");
    tick(); tick();
    pulseBlock();
    waitWords(base_words + 8, "second pass block 2 words");
    tick(); tick();
    regRead(REG_STATUS, rd);
    checkOutput("case 4 STATUS", rd, 32'd7);

    $display("[TB] case 5: stop during a stalled fetch");
    model_cycles = 4;
    setup(32'h0001_0000, 32'd4, 32'd4, 32'd1, 32'd0);
    addr_q.push_back(32'h0001_0000);
    ack_delay = 3;
    discard = 1'b1;
    base_words = words_seen;
    pulseBlock();
    regWrite(REG_STOP, 32'd0);
    checkOutput("dma_cyc held after stop", {31'd0, dma_cyc}, 32'd1);
    repeat (6) tick();
    checkOutput("dma_cyc dropped", {31'd0, dma_cyc}, 32'd0);
    checkOutput("stopped word discarded", 32'(words_seen - base_words), 32'd0);
    regRead(REG_STATUS, rd);
    checkOutput("case 5 STATUS", rd, 32'd0);
    discard = 1'b0;
    ack_delay = 0;
    base_cyc = cyc_seen;
    pulseBlock();
    repeat (6) tick();
    checkOutput("idle after stop", 32'(cyc_seen - base_cyc), 32'd0);

    $display("[TB] case 6: zero-length transfer");
    base_cyc = cyc_seen;
    setup(32'h0001_0000, 32'd4, 32'd0, 32'd2, 32'd0);
    checkOutput("zero cycles xfer_done", {31'd0, xfer_done}, 32'd1);
    pulseBlock();
    repeat (6) tick();
    checkOutput("zero cycles no fetch", 32'(cyc_seen - base_cyc), 32'd0);
    regRead(REG_STATUS, rd);
    checkOutput("case 6 STATUS", rd, 32'd6);

    checkOutput("address queue drained", 32'(addr_q.size()), 32'd0);
    checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);
    checkOutput("protocol violations", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
